// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide sequencer.
package md_pkg;

    localparam int          ITER    = 32;
    localparam int          CNT_W   = $clog2(ITER);
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the sequencer: a shift-add multiply step or a restoring divide step.
module md_step
    import md_pkg::*;
(
    input  step_mode_e  mode,
    input  logic [63:0] acc,
    input  logic [31:0] rem,
    input  logic [31:0] opb,
    output logic [63:0] acc_nxt,
    output logic [31:0] rem_nxt
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [33:0] diff;

    always_comb begin
        sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        rem_sh  = {rem, acc[31]};
        diff    = {1'b0, rem_sh} - {2'b00, opb};
        acc_nxt = acc;
        rem_nxt = rem;
        if (mode == STEP_MUL) begin
            // multiplier sits in the low half and is consumed LSB first
            acc_nxt = {sum, acc[31:1]};
        end else if (!diff[33]) begin
            rem_nxt = diff[31:0];
            acc_nxt = {32'd0, acc[30:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[31:0];
            acc_nxt = {32'd0, acc[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctl.sv
// Iterative MULT/DIV sequencer owning HI/LO; stalls EXM1 while an operation is in flight.
// state | meaning
// IDLE  | no operation in flight; MT/MF ops and new mul/div accepted here
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// FIX   | sign fixup and HI/LO write
module muldiv_ctl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        ExtStall,
    input  logic        InstrVal_ID,
    input  logic [3:0]  MdOp_ID,
    input  logic [31:0] RsVal_ID,
    input  logic [31:0] RtVal_ID,
    output logic        MdStall_EXM1,
    output logic [31:0] MdResult_EXM1,
    output logic        MdBusy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      opb_q, opb_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div0_q, div0_d;
    logic             is_div_q, is_div_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        op_valid, req, accept, signed_op;
    logic [31:0] rs_mag, rt_mag;
    logic [63:0] step_acc, prod_fix;
    logic [31:0] step_rem, quo_fix, rem_fix;
    step_mode_e  step_mode;

    assign op_valid     = (MdOp_ID >= 4'd1) && (MdOp_ID <= 4'd8);
    assign req          = InstrVal_ID & op_valid & ~flush;
    assign MdBusy       = (state_q != IDLE);
    assign MdStall_EXM1 = req & MdBusy;
    assign accept       = req & ~MdBusy & ~ExtStall;
    assign Hi           = hi_q;
    assign Lo           = lo_q;

    assign signed_op = (MdOp_ID == OP_MULT) || (MdOp_ID == OP_DIV);
    assign rs_mag    = signed_op ? abs32(RsVal_ID) : RsVal_ID;
    assign rt_mag    = signed_op ? abs32(RtVal_ID) : RtVal_ID;
    assign step_mode = (state_q == DIV) ? STEP_DIV : STEP_MUL;

    md_step u_step (
        .mode    (step_mode),
        .acc     (acc_q),
        .rem     (rem_q),
        .opb     (opb_q),
        .acc_nxt (step_acc),
        .rem_nxt (step_rem)
    );

    always_comb begin
        MdResult_EXM1 = 32'd0;
        if (MdOp_ID == OP_MFHI) MdResult_EXM1 = hi_q;
        else if (MdOp_ID == OP_MFLO) MdResult_EXM1 = lo_q;
    end

    always_comb begin
        prod_fix = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = neg_hi_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (MdOp_ID)
                        OP_MULT, OP_MULTU: begin
                            state_d  = MUL;
                            cnt_d    = CNT_W'(ITER - 1);
                            acc_d    = {32'd0, rt_mag};
                            opb_d    = rs_mag;
                            rem_d    = 32'd0;
                            neg_lo_d = signed_op & (RsVal_ID[31] ^ RtVal_ID[31]);
                            neg_hi_d = 1'b0;
                            div0_d   = 1'b0;
                            is_div_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = DIV;
                            cnt_d    = CNT_W'(ITER - 1);
                            acc_d    = {32'd0, rs_mag};
                            opb_d    = rt_mag;
                            rem_d    = 32'd0;
                            neg_lo_d = signed_op & (RsVal_ID[31] ^ RtVal_ID[31]);
                            neg_hi_d = signed_op & RsVal_ID[31];
                            div0_d   = (RtVal_ID == 32'd0);
                            is_div_d = 1'b1;
                        end
                        OP_MTHI: hi_d = RsVal_ID;
                        OP_MTLO: lo_d = RsVal_ID;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                acc_d = step_acc;
                rem_d = step_rem;
                if (cnt_q == '0) state_d = FIX;
                else cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                state_d = IDLE;
                if (is_div_q) begin
                    // with a zero divisor the remainder path already returns Rs after fixup
                    hi_d = rem_fix;
                    lo_d = div0_q ? DIV0_LO : quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctl.sv
// Scenario bench for muldiv_ctl: results predicted by a behavioural model and queued until completion.
module tb_muldiv_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ExtStall;
    logic        InstrVal_ID;
    logic [3:0]  MdOp_ID;
    logic [31:0] RsVal_ID;
    logic [31:0] RtVal_ID;
    logic        MdStall_EXM1;
    logic [31:0] MdResult_EXM1;
    logic        MdBusy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi, m_lo;

    localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIVS = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

    muldiv_ctl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .ExtStall      (ExtStall),
        .InstrVal_ID   (InstrVal_ID),
        .MdOp_ID       (MdOp_ID),
        .RsVal_ID      (RsVal_ID),
        .RtVal_ID      (RtVal_ID),
        .MdStall_EXM1  (MdStall_EXM1),
        .MdResult_EXM1 (MdResult_EXM1),
        .MdBusy        (MdBusy),
        .Hi            (Hi),
        .Lo            (Lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic signed [63:0] p;
        logic [31:0] q, r;
        case (op)
            MULT: begin
                p = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
                return p;
            end
            MULTU: return {32'd0, rs} * {32'd0, rt};
            DIVS: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(rs) / $signed(rt);
                r = $signed(rs) % $signed(rt);
                return {r, q};
            end
            DIVU: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                return {rs % rt, rs / rt};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        InstrVal_ID = (op != 4'd0);
        MdOp_ID     = op;
        RsVal_ID    = rs;
        RtVal_ID    = rt;
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        drive(op, rs, rt);
        tick();
        sb.push_back(ref_md(op, rs, rt));
        drive(4'd0, 32'd0, 32'd0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (MdBusy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; ExtStall = 1'b0;
        drive(MULT, 32'd5, 32'd6);
        tick(); tick();
        n_checks++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", MdBusy); end
        n_checks++; if (MdStall_EXM1 !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", MdStall_EXM1); end
        n_checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", Hi, Lo); end
        drive(4'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult_mflo();
        int s;
        logic [63:0] e;
        drive(MULT, 32'd7, 32'hFFFF_FFFD);
        n_checks++; if (MdStall_EXM1 !== 1'b0) begin n_fail++; $display("FAIL mult_first_stall: got %b want 0", MdStall_EXM1); end
        tick();
        sb.push_back(ref_md(MULT, 32'd7, 32'hFFFF_FFFD));
        drive(MFLO, 32'd0, 32'd0);
        s = 0;
        while (MdStall_EXM1 === 1'b1 && s < 100) begin tick(); s++; end
        e = sb.pop_front();
        m_hi = e[63:32]; m_lo = e[31:0];
        n_checks++; if (s != 33) begin n_fail++; $display("FAIL mflo_stall_cycles: got %0d want 33", s); end
        n_checks++; if (MdResult_EXM1 !== e[31:0]) begin n_fail++; $display("FAIL mflo_result: got %h want %h", MdResult_EXM1, e[31:0]); end
        n_checks++; if (Hi !== e[63:32]) begin n_fail++; $display("FAIL mult_hi: got %h want %h", Hi, e[63:32]); end
        tick();
        drive(4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_multu_timing();
        logic [63:0] e;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) tick();
        n_checks++; if (MdBusy !== 1'b1 || Hi !== m_hi || Lo !== m_lo) begin n_fail++; $display("FAIL multu_fix_cycle: got busy=%b %h/%h want busy=1 %h/%h", MdBusy, Hi, Lo, m_hi, m_lo); end
        tick();
        e = sb.pop_front();
        m_hi = e[63:32]; m_lo = e[31:0];
        n_checks++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL multu_done_busy: got %b want 0", MdBusy); end
        n_checks++; if (Hi !== e[63:32] || Lo !== e[31:0]) begin n_fail++; $display("FAIL multu_result: got %h/%h want %h/%h", Hi, Lo, e[63:32], e[31:0]); end
    endtask

    task automatic test_div_cases();
        logic [3:0]  ops[6] = '{DIVS, DIVS, DIVU, DIVS, DIVU, DIVS};
        logic [31:0] rss[6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FF00, 32'd7, 32'd100};
        logic [31:0] rts[6] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        int n;
        logic [63:0] e;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], rss[i], rts[i]);
            wait_idle(n);
            e = sb.pop_front();
            m_hi = e[63:32]; m_lo = e[31:0];
            n_checks++; if (n != 33) begin n_fail++; $display("FAIL div%0d_latency: got %0d want 33", i, n); end
            n_checks++; if (Hi !== e[63:32] || Lo !== e[31:0]) begin n_fail++; $display("FAIL div%0d_result: got %h/%h want %h/%h", i, Hi, Lo, e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] rs, rt;
        logic [63:0] e;
        int n;
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(1, 4));
            rs = $urandom();
            rt = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
            if (i % 3 == 1) rt = 32'($urandom_range(1, 20));
            issue(op, rs, rt);
            wait_idle(n);
            e = sb.pop_front();
            m_hi = e[63:32]; m_lo = e[31:0];
            n_checks++; if (Hi !== e[63:32] || Lo !== e[31:0]) begin n_fail++; $display("FAIL rand%0d op%0d %h,%h: got %h/%h want %h/%h", i, op, rs, rt, Hi, Lo, e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_flush_same();
        flush = 1'b1;
        drive(DIVS, 32'd9, 32'd2);
        n_checks++; if (MdStall_EXM1 !== 1'b0) begin n_fail++; $display("FAIL flush_same_stall: got %b want 0", MdStall_EXM1); end
        tick();
        drive(MTHI, 32'h5555_AAAA, 32'd0);
        tick();
        flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        n_checks++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL flush_same_busy: got %b want 0", MdBusy); end
        tick(); tick();
        n_checks++; if (Hi !== m_hi || Lo !== m_lo) begin n_fail++; $display("FAIL flush_same_hilo: got %h/%h want %h/%h", Hi, Lo, m_hi, m_lo); end
    endtask

    task automatic test_flush_busy();
        int n;
        logic [63:0] e;
        issue(MULT, 32'hFFFF_0000, 32'h0000_1234);
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b1;
        drive(MFHI, 32'd0, 32'd0);
        n_checks++; if (MdStall_EXM1 !== 1'b0) begin n_fail++; $display("FAIL flush_busy_stall: got %b want 0", MdStall_EXM1); end
        tick(); tick();
        flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        wait_idle(n);
        e = sb.pop_front();
        m_hi = e[63:32]; m_lo = e[31:0];
        n_checks++; if (n + 7 != 33) begin n_fail++; $display("FAIL flush_busy_latency: got %0d want 33", n + 7); end
        n_checks++; if (Hi !== e[63:32] || Lo !== e[31:0]) begin n_fail++; $display("FAIL flush_busy_result: got %h/%h want %h/%h", Hi, Lo, e[63:32], e[31:0]); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        issue(DIVS, 32'd1000, 32'd7);
        e = sb.pop_back();
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_checks++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", MdBusy); end
        n_checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_hilo: got %h/%h want 0/0 (discarded %h)", Hi, Lo, e); end
        for (int i = 0; i < 40; i++) tick();
        n_checks++; if (MdBusy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_late: got busy=%b %h/%h want 0 0/0", MdBusy, Hi, Lo); end
    endtask

    task automatic test_mthi_mfhi();
        drive(MTHI, 32'h0000_1234, 32'd0);
        n_checks++; if (MdStall_EXM1 !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b want 0", MdStall_EXM1); end
        tick();
        m_hi = 32'h0000_1234;
        drive(MFHI, 32'd0, 32'd0);
        n_checks++; if (MdStall_EXM1 !== 1'b0) begin n_fail++; $display("FAIL mfhi_stall: got %b want 0", MdStall_EXM1); end
        n_checks++; if (MdResult_EXM1 !== 32'h0000_1234) begin n_fail++; $display("FAIL mfhi_result: got %h want 00001234", MdResult_EXM1); end
        tick();
        drive(MTLO, 32'hCAFE_F00D, 32'd0);
        tick();
        m_lo = 32'hCAFE_F00D;
        drive(MFLO, 32'd0, 32'd0);
        n_checks++; if (MdResult_EXM1 !== 32'hCAFE_F00D || Hi !== m_hi) begin n_fail++; $display("FAIL mtlo_mflo: got %h hi=%h want cafef00d hi=%h", MdResult_EXM1, Hi, m_hi); end
        tick();
        drive(4'd9, 32'd3, 32'd4);
        n_checks++; if (MdResult_EXM1 !== 32'd0) begin n_fail++; $display("FAIL badop_result: got %h want 0", MdResult_EXM1); end
        tick();
        n_checks++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL badop_busy: got %b want 0", MdBusy); end
        drive(4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        int s, n;
        logic [63:0] e;
        issue(MULT, 32'h8000_0000, 32'h8000_0000);
        drive(MULT, 32'hFFFF_FFFF, 32'd12345);
        s = 0;
        while (MdStall_EXM1 === 1'b1 && s < 100) begin tick(); s++; end
        e = sb.pop_front();
        m_hi = e[63:32]; m_lo = e[31:0];
        n_checks++; if (s != 33) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 33", s); end
        n_checks++; if (Hi !== e[63:32] || Lo !== e[31:0]) begin n_fail++; $display("FAIL b2b_first: got %h/%h want %h/%h", Hi, Lo, e[63:32], e[31:0]); end
        tick();
        sb.push_back(ref_md(MULT, 32'hFFFF_FFFF, 32'd12345));
        drive(4'd0, 32'd0, 32'd0);
        n_checks++; if (MdBusy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b want 1", MdBusy); end
        wait_idle(n);
        e = sb.pop_front();
        m_hi = e[63:32]; m_lo = e[31:0];
        n_checks++; if (n != 33 || Hi !== e[63:32] || Lo !== e[31:0]) begin n_fail++; $display("FAIL b2b_second: got n=%0d %h/%h want n=33 %h/%h", n, Hi, Lo, e[63:32], e[31:0]); end
    endtask

    task automatic test_extstall();
        int n;
        logic [63:0] e;
        ExtStall = 1'b1;
        drive(MULTU, 32'd12345, 32'd6789);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (MdBusy !== 1'b0 || MdStall_EXM1 !== 1'b0) begin n_fail++; $display("FAIL extstall_hold%0d: got busy=%b stall=%b want 0 0", i, MdBusy, MdStall_EXM1); end
        end
        ExtStall = 1'b0;
        #1;
        tick();
        sb.push_back(ref_md(MULTU, 32'd12345, 32'd6789));
        drive(4'd0, 32'd0, 32'd0);
        n_checks++; if (MdBusy !== 1'b1) begin n_fail++; $display("FAIL extstall_accept: got %b want 1", MdBusy); end
        wait_idle(n);
        e = sb.pop_front();
        m_hi = e[63:32]; m_lo = e[31:0];
        n_checks++; if (n != 33 || Hi !== e[63:32] || Lo !== e[31:0]) begin n_fail++; $display("FAIL extstall_result: got n=%0d %h/%h want n=33 %h/%h", n, Hi, Lo, e[63:32], e[31:0]); end
    endtask

    initial begin
        test_reset();
        test_mult_mflo();
        test_multu_timing();
        test_div_cases();
        test_random();
        test_flush_same();
        test_flush_busy();
        test_mthi_mfhi();
        test_back_to_back();
        test_extstall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
